// File: rtl/chan_rendezvous.sv
`default_nettype none
// ============================================================================
// Module      : chan_rendezvous
// Description : Channel rendezvous unit behind the per-CPU channel controller.
//               Takes a two-beat request (beat 1: CHAN_SET/CHAN_GET with
//               channel address and data, beat 2: THREAD_ADDRESS). It keeps a
//               small table of pending channel values and answers every
//               accepted request with a one-cycle reply pulse (RES_WR, RES_RD
//               or NO_RESULTS).
// Ports       : clk, rst (async, active-low), clk_oe (cycle enable)
//               chan_msg_strb_i, cpu_msg_in, addr_in, data_in   - requests
//               cpu_msg_out, addr_out, data_out, cpu_msg_pulse  - reply
//               busy                                            - in progress
// Options     : CHAN_OWNER_CHK_EN - remember the writer thread of each entry
//               and refuse a GET issued by that same thread.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 1
`endif
`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET 2
`endif
`ifndef CPU_R_THREAD_ADDRESS
`define CPU_R_THREAD_ADDRESS 3
`endif
`ifndef CPU_R_CHAN_RES_WR
`define CPU_R_CHAN_RES_WR 4
`endif
`ifndef CPU_R_CHAN_RES_RD
`define CPU_R_CHAN_RES_RD 5
`endif
`ifndef CPU_R_CHAN_NO_RESULTS
`define CPU_R_CHAN_NO_RESULTS 6
`endif

module chan_rendezvous #(
    parameter int CHAN_NUM = 4,
    parameter int TMO_CYC  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_oe,
    input  logic                      chan_msg_strb_i,
    input  logic [`CPU_MSG_SIZE0:0]   cpu_msg_in,
    input  logic [`ADDR_SIZE0:0]      addr_in,
    input  logic [`DATA_SIZE0:0]      data_in,
    output logic [`CPU_MSG_SIZE0:0]   cpu_msg_out,
    output logic [`ADDR_SIZE0:0]      addr_out,
    output logic [`DATA_SIZE0:0]      data_out,
    output logic                      cpu_msg_pulse,
    output logic                      busy
);

    localparam int MSG_W = `CPU_MSG_SIZE0 + 1;
    localparam int AW    = `ADDR_SIZE0 + 1;
    localparam int DW    = `DATA_SIZE0 + 1;
    localparam int IDX_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    localparam logic [MSG_W-1:0] c_msg_set   = MSG_W'(`CPU_R_CHAN_SET);
    localparam logic [MSG_W-1:0] c_msg_get   = MSG_W'(`CPU_R_CHAN_GET);
    localparam logic [MSG_W-1:0] c_msg_thr   = MSG_W'(`CPU_R_THREAD_ADDRESS);
    localparam logic [MSG_W-1:0] c_msg_wr    = MSG_W'(`CPU_R_CHAN_RES_WR);
    localparam logic [MSG_W-1:0] c_msg_rd    = MSG_W'(`CPU_R_CHAN_RES_RD);
    localparam logic [MSG_W-1:0] c_msg_nores = MSG_W'(`CPU_R_CHAN_NO_RESULTS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_THRD = 2'd1,
        ST_LOOKUP    = 2'd2,
        ST_REPLY     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request
    logic             r_req_set;
    logic [AW-1:0]    r_req_chan;
    logic [AW-1:0]    r_req_thr;
    logic [DW-1:0]    r_req_data;
    logic [TMO_W-1:0] r_tmo_cnt;

    // Channel table
    logic [CHAN_NUM-1:0] r_valid;
    logic [CHAN_NUM-1:0] r_full;
    logic [AW-1:0]       r_chan [CHAN_NUM];
    logic [DW-1:0]       r_data [CHAN_NUM];
`ifdef CHAN_OWNER_CHK_EN
    logic [AW-1:0]       r_owner [CHAN_NUM];
`endif

    // Reply registers
    logic [MSG_W-1:0] r_msg_out;
    logic [AW-1:0]    r_addr_out;
    logic [DW-1:0]    r_data_out;
    logic             r_pulse;

    logic             w_beat1;
    logic             w_beat2;
    logic             w_tmo;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_free;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_own_block;
    logic             w_store;
    logic [IDX_W-1:0] w_store_idx;
    logic             w_release;
    logic [MSG_W-1:0] w_res_msg;
    logic [DW-1:0]    w_res_data;

    assign w_beat1 = chan_msg_strb_i && ((cpu_msg_in == c_msg_set) || (cpu_msg_in == c_msg_get));
    assign w_beat2 = (cpu_msg_in == c_msg_thr);
    // Counter holds the number of idle waits already spent; the last allowed
    // wait is the one that sees TMO_CYC-1.
    assign w_tmo   = (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (clk_oe) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_beat1) w_state_nxt = ST_WAIT_THRD;
            ST_WAIT_THRD: begin
                if (w_beat2)    w_state_nxt = ST_LOOKUP;
                else if (w_tmo) w_state_nxt = ST_IDLE;
            end
            ST_LOOKUP:    w_state_nxt = ST_REPLY;
            ST_REPLY:     w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Table search: walking downward leaves the lowest matching index.
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = CHAN_NUM - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_chan[i] == r_req_chan)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef CHAN_OWNER_CHK_EN
    assign w_own_block = (r_owner[w_hit_idx] == r_req_thr);
`else
    assign w_own_block = 1'b0;
`endif

    always_comb begin
        w_res_msg   = c_msg_nores;
        w_res_data  = '0;
        w_store     = 1'b0;
        w_store_idx = w_hit_idx;
        w_release   = 1'b0;
        if (r_req_set) begin
            if (w_hit) begin
                if (!r_full[w_hit_idx]) begin
                    w_store   = 1'b1;
                    w_res_msg = c_msg_wr;
                end
            end else if (w_free) begin
                w_store     = 1'b1;
                w_store_idx = w_free_idx;
                w_res_msg   = c_msg_wr;
            end
        end else if (w_hit && r_full[w_hit_idx] && !w_own_block) begin
            w_release  = 1'b1;
            w_res_msg  = c_msg_rd;
            w_res_data = r_data[w_hit_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Request latches, entry flags and reply registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_set  <= 1'b0;
            r_req_chan <= '0;
            r_req_thr  <= '0;
            r_req_data <= '0;
            r_tmo_cnt  <= '0;
            r_valid    <= '0;
            r_full     <= '0;
            r_msg_out  <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_pulse    <= 1'b0;
        end else if (clk_oe) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_beat1) begin
                        r_req_set  <= (cpu_msg_in == c_msg_set);
                        r_req_chan <= addr_in;
                        r_req_data <= data_in;
                        r_tmo_cnt  <= '0;
                    end
                end
                ST_WAIT_THRD: begin
                    if (w_beat2) r_req_thr <= addr_in;
                    else         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                end
                ST_LOOKUP: begin
                    if (w_store) begin
                        r_valid[w_store_idx] <= 1'b1;
                        r_full[w_store_idx]  <= 1'b1;
                    end
                    if (w_release) begin
                        r_valid[w_hit_idx] <= 1'b0;
                        r_full[w_hit_idx]  <= 1'b0;
                    end
                    r_msg_out  <= w_res_msg;
                    r_addr_out <= r_req_thr;
                    r_data_out <= w_res_data;
                    r_pulse    <= 1'b1;
                end
                ST_REPLY: begin
                    r_msg_out  <= '0;
                    r_addr_out <= '0;
                    r_data_out <= '0;
                    r_pulse    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Entry payload needs no reset; the valid/full flags gate its use.
    always_ff @(posedge clk) begin
        if (clk_oe && (r_state == ST_LOOKUP) && w_store) begin
            r_chan[w_store_idx]  <= r_req_chan;
            r_data[w_store_idx]  <= r_req_data;
`ifdef CHAN_OWNER_CHK_EN
            r_owner[w_store_idx] <= r_req_thr;
`endif
        end
    end

    assign cpu_msg_out   = r_msg_out;
    assign addr_out      = r_addr_out;
    assign data_out      = r_data_out;
    assign cpu_msg_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_chan_rendezvous.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_chan_rendezvous
// Description : Self-checking bench for chan_rendezvous. A transaction-level
//               model (associative channel table) predicts the outputs on
//               every cycle; directed transactions also carry literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 1
`endif
`ifndef CPU_R_CHAN_GET
`define CPU_R_CHAN_GET 2
`endif
`ifndef CPU_R_THREAD_ADDRESS
`define CPU_R_THREAD_ADDRESS 3
`endif
`ifndef CPU_R_CHAN_RES_WR
`define CPU_R_CHAN_RES_WR 4
`endif
`ifndef CPU_R_CHAN_RES_RD
`define CPU_R_CHAN_RES_RD 5
`endif
`ifndef CPU_R_CHAN_NO_RESULTS
`define CPU_R_CHAN_NO_RESULTS 6
`endif

module tb_chan_rendezvous;

    localparam int CHAN_NUM = 4;
    localparam int TMO_CYC  = 8;
    localparam int MW = `CPU_MSG_SIZE0 + 1;
    localparam int AW = `ADDR_SIZE0 + 1;
    localparam int DW = `DATA_SIZE0 + 1;

    localparam logic [MW-1:0] SET   = MW'(`CPU_R_CHAN_SET);
    localparam logic [MW-1:0] GET   = MW'(`CPU_R_CHAN_GET);
    localparam logic [MW-1:0] THR   = MW'(`CPU_R_THREAD_ADDRESS);
    localparam logic [MW-1:0] WR    = MW'(`CPU_R_CHAN_RES_WR);
    localparam logic [MW-1:0] RD    = MW'(`CPU_R_CHAN_RES_RD);
    localparam logic [MW-1:0] NORES = MW'(`CPU_R_CHAN_NO_RESULTS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_oe = 1'b1;
    logic          strb = 1'b0;
    logic [MW-1:0] msg_in = '0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] data_in = '0;
    logic [MW-1:0] cpu_msg_out;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic          cpu_msg_pulse;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chan_rendezvous #(.CHAN_NUM(CHAN_NUM), .TMO_CYC(TMO_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_oe          (clk_oe),
        .chan_msg_strb_i (strb),
        .cpu_msg_in      (msg_in),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .cpu_msg_out     (cpu_msg_out),
        .addr_out        (addr_out),
        .data_out        (data_out),
        .cpu_msg_pulse   (cpu_msg_pulse),
        .busy            (busy)
    );

    // ------------------------------------------------------------------------
    // Transaction-level model: channel table is a map chan -> value, capacity
    // CHAN_NUM. Timing is tracked as "waiting for beat 2", "reply due on the
    // next enabled edge" and "reply showing".
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_tab [int];
    logic [AW-1:0] m_own [int];
    bit            m_busy = 0, m_wait = 0, m_due = 0, m_pulse = 0;
    int            m_cnt = 0;
    bit            m_is_set = 0;
    logic [AW-1:0] m_chan = '0;
    logic [DW-1:0] m_data = '0;
    logic [MW-1:0] p_msg = '0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;
    logic [MW-1:0] e_msg = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;

    task automatic model_resolve(input logic [AW-1:0] thr);
        int k;
        k = int'(m_chan);
        p_msg  = NORES;
        p_addr = thr;
        p_data = '0;
        if (m_is_set) begin
            if (!m_tab.exists(k) && m_tab.num() < CHAN_NUM) begin
                m_tab[k] = m_data;
                m_own[k] = thr;
                p_msg    = WR;
            end
        end else if (m_tab.exists(k)) begin
`ifdef CHAN_OWNER_CHK_EN
            if (m_own[k] != thr) begin
`else
            begin
`endif
                p_msg  = RD;
                p_data = m_tab[k];
                m_tab.delete(k);
                m_own.delete(k);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tab.delete();
            m_own.delete();
            m_busy = 0; m_wait = 0; m_due = 0; m_pulse = 0; m_cnt = 0;
            e_msg = '0; e_addr = '0; e_data = '0;
        end else if (clk_oe) begin
            if (m_pulse) begin
                m_pulse = 0; m_busy = 0;
                e_msg = '0; e_addr = '0; e_data = '0;
            end else if (m_due) begin
                m_due = 0; m_pulse = 1;
                e_msg = p_msg; e_addr = p_addr; e_data = p_data;
            end else if (m_wait) begin
                if (msg_in == THR) begin
                    m_wait = 0;
                    model_resolve(addr_in);
                    m_due = 1;
                end else begin
                    m_cnt++;
                    if (m_cnt == TMO_CYC) begin
                        m_wait = 0; m_busy = 0;
                    end
                end
            end else if (!m_busy && strb && (msg_in == SET || msg_in == GET)) begin
                m_busy = 1; m_wait = 1; m_cnt = 0;
                m_is_set = (msg_in == SET);
                m_chan = addr_in;
                m_data = data_in;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (cpu_msg_pulse !== m_pulse || cpu_msg_out !== e_msg || addr_out !== e_addr ||
                data_out !== e_data || busy !== m_busy) begin
                errors++;
                $display("FAIL model_cmp t=%0t: actual pulse=%b msg=%h addr=%h data=%h busy=%b, required pulse=%b msg=%h addr=%h data=%h busy=%b",
                         $time, cpu_msg_pulse, cpu_msg_out, addr_out, data_out, busy,
                         m_pulse, e_msg, e_addr, e_data, m_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full request with literal expectations on the reply.
    task automatic txn(input bit is_set, input logic [AW-1:0] ch, input logic [DW-1:0] d,
                       input logic [AW-1:0] thr, input int stall,
                       input logic [MW-1:0] exp_msg, input logic [DW-1:0] exp_data,
                       input string name);
        @(negedge clk);
        clk_oe = 1'b1; strb = 1'b1; msg_in = is_set ? SET : GET; addr_in = ch; data_in = d;
        @(negedge clk);
        strb = 1'b0; msg_in = '0; addr_in = '0; data_in = '0;
        if (stall > 0) begin
            clk_oe = 1'b0;
            repeat (stall) @(negedge clk);
            clk_oe = 1'b1;
        end
        msg_in = THR; addr_in = thr;
        @(negedge clk);
        msg_in = '0; addr_in = '0;
        chk({name, "_latency"}, 64'(cpu_msg_pulse), 64'd0);
        @(negedge clk);
        checks++;
        if (!cpu_msg_pulse || cpu_msg_out !== exp_msg || addr_out !== thr || data_out !== exp_data) begin
            errors++;
            $display("FAIL %s: actual pulse=%b msg=%h addr=%h data=%h, required pulse=1 msg=%h addr=%h data=%h",
                     name, cpu_msg_pulse, cpu_msg_out, addr_out, data_out, exp_msg, thr, exp_data);
        end
        if (stall > 0) begin
            clk_oe = 1'b0;
            repeat (stall) @(negedge clk);
            chk({name, "_pulse_hold"}, 64'(cpu_msg_pulse), 64'd1);
            clk_oe = 1'b1;
        end
        @(negedge clk);
        chk({name, "_pulse_end"}, {62'd0, cpu_msg_pulse, busy}, 64'd0);
    endtask

    initial begin : main
        int n;
        // Asynchronous reset
        #1 rst = 1'b0;
        #2;
        chk("reset_outputs", {cpu_msg_out, addr_out, data_out, cpu_msg_pulse, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic rendezvous
        txn(1, 16'h0040, 32'h1234, 16'h0100, 0, WR, 32'h0, "set_40");
        txn(0, 16'h0040, 32'h0,    16'h0200, 2, RD, 32'h1234, "get_40");
        txn(0, 16'h0040, 32'h0,    16'h0200, 0, NORES, 32'h0, "get_40_freed");
        txn(0, 16'h0050, 32'h0,    16'h0300, 0, NORES, 32'h0, "get_50_empty");

        // Double SET on the same channel
        txn(1, 16'h0040, 32'hAAAA, 16'h0100, 0, WR, 32'h0, "set_40_a");
        txn(1, 16'h0040, 32'hBBBB, 16'h0100, 1, NORES, 32'h0, "set_40_b");
        txn(0, 16'h0040, 32'h0,    16'h0300, 0, RD, 32'hAAAA, "get_40_a");

        // Capacity
        for (int k = 1; k <= 5; k++)
            txn(1, AW'(k), DW'(32'h11 * k), 16'h0100, 0, (k <= 4) ? WR : NORES, 32'h0, "set_cap");
        txn(0, 16'h0001, 32'h0, 16'h0200, 0, RD, 32'h11, "get_1");
        txn(1, 16'h0005, 32'h55, 16'h0100, 0, WR, 32'h0, "set_5_reuse");
        for (int k = 2; k <= 5; k++)
            txn(0, AW'(k), 32'h0, 16'h0200, 0, RD, DW'(32'h11 * k), "drain");

        // Channel 0 and full-width address compare
        txn(1, 16'h0000, 32'hC0DE, 16'h0100, 0, WR, 32'h0, "set_ch0");
        txn(1, 16'h8040, 32'h8040, 16'h0100, 0, WR, 32'h0, "set_8040");
        txn(0, 16'h0040, 32'h0,    16'h0200, 0, NORES, 32'h0, "get_40_nowrap");
        txn(0, 16'h8040, 32'h0,    16'h0200, 0, RD, 32'h8040, "get_8040");
        txn(0, 16'h0000, 32'h0,    16'h0200, 0, RD, 32'hC0DE, "get_ch0");

        // Writer reading its own value
        txn(1, 16'h0040, 32'h5678, 16'h0100, 0, WR, 32'h0, "own_set");
`ifdef CHAN_OWNER_CHK_EN
        txn(0, 16'h0040, 32'h0, 16'h0100, 0, NORES, 32'h0, "own_get_self");
        txn(0, 16'h0040, 32'h0, 16'h0200, 0, RD, 32'h5678, "own_get_other");
`else
        txn(0, 16'h0040, 32'h0, 16'h0100, 0, RD, 32'h5678, "own_get_self");
`endif

        // Strobe with a non-request code is ignored
        @(negedge clk);
        strb = 1'b1; msg_in = THR; addr_in = 16'h0040;
        @(negedge clk);
        strb = 1'b0; msg_in = '0; addr_in = '0;
        chk("bad_code_ignored", 64'(busy), 64'd0);

        // Timeout, with a strobe landing while busy
        @(negedge clk);
        strb = 1'b1; msg_in = SET; addr_in = 16'h0060; data_in = 32'h66;
        @(negedge clk);
        strb = 1'b0; msg_in = '0; addr_in = '0; data_in = '0;
        n = 0;
        while (busy && n < 30) begin
            n++;
            if (n == 3) begin strb = 1'b1; msg_in = GET; addr_in = 16'h0060; end
            else        begin strb = 1'b0; msg_in = '0; addr_in = '0; end
            @(negedge clk);
        end
        strb = 1'b0; msg_in = '0; addr_in = '0;
        chk("timeout_cycles", 64'(n), 64'(TMO_CYC));
        repeat (2) @(negedge clk);
        chk("timeout_no_pulse", 64'(cpu_msg_pulse), 64'd0);
        txn(0, 16'h0060, 32'h0, 16'h0200, 0, NORES, 32'h0, "timeout_no_store");

        // Reset while waiting for beat 2 drops the request and the table
        txn(1, 16'h0070, 32'h77, 16'h0100, 0, WR, 32'h0, "set_70");
        @(negedge clk);
        strb = 1'b1; msg_in = SET; addr_in = 16'h0071; data_in = 32'h71;
        @(negedge clk);
        strb = 1'b0; msg_in = '0; addr_in = '0; data_in = '0;
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_midreq", {cpu_msg_out, addr_out, data_out, cpu_msg_pulse, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 16'h0070, 32'h0, 16'h0200, 0, NORES, 32'h0, "get_70_after_rst");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/chan_rendezvous.md
Name: chan_rendezvous

Overview:
- Channel rendezvous unit directly downstream of the per-CPU channel controller.
- Consumes the two-beat channel request the controller issues:
  - beat 1: CPU_R_CHAN_SET or CPU_R_CHAN_GET with strobe;
  - beat 2: CPU_R_THREAD_ADDRESS.
- Keeps a small table of pending channel values and answers each request with one reply pulse: CPU_R_CHAN_RES_WR, CPU_R_CHAN_RES_RD or CPU_R_CHAN_NO_RESULTS.
- The controller consumes that reply.

Parameters:
- CHAN_NUM, 4, number of table entries (channels pending at once); 2..16.
- TMO_CYC, 8, clk_oe-qualified cycles to wait for beat 2 before abandoning the request.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- clk_oe  in  1  cycle enable; state advances only on clk edges with clk_oe=1.
- chan_msg_strb_i  in  1  qualifies beat 1.
- cpu_msg_in  in  `CPU_MSG_SIZE0+1  message code from controller.
- addr_in  in  `ADDR_SIZE0+1  beat 1: channel address; beat 2: thread address.
- data_in  in  `DATA_SIZE0+1  beat 1 SET: value to send.
- cpu_msg_out  out  `CPU_MSG_SIZE0+1  reply code; 0 when cpu_msg_pulse=0.
- addr_out  out  `ADDR_SIZE0+1  requester thread address; 0 when no pulse.
- data_out  out  `DATA_SIZE0+1  read value on RES_RD, else 0.
- cpu_msg_pulse  out  1  reply valid, exactly one clk_oe cycle.
- busy  out  1  request in progress; new beat-1 strobes are ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - all table entries invalid; FSM to IDLE.
  - cpu_msg_pulse=0, busy=0; reply registers 0, so cpu_msg_out, addr_out and data_out read 0.
  - Applies mid-request: the in-flight request is dropped with no reply.
- clk_oe=0 edges: no state change. A pulse already high stays high until the next clk_oe=1 edge.
- Table entry fields: valid, full, chan_addr, data and, with the option, owner.
- IDLE:
  - On chan_msg_strb_i=1 with cpu_msg_in equal to CPU_R_CHAN_SET or CPU_R_CHAN_GET: latch op, addr_in and data_in; busy=1; go to WAIT_THRD; clear the timeout counter.
  - Strobe with any other code is ignored.
- WAIT_THRD:
  - On cpu_msg_in == CPU_R_THREAD_ADDRESS: latch addr_in as thread address; go to LOOKUP.
  - Other codes, including 0, keep waiting; the counter increments.
  - When the counter reaches TMO_CYC: go to IDLE, busy=0, no reply.
- LOOKUP (one cycle): parallel compare of the latched channel address against every valid entry. At most one hit, guaranteed by allocation. Resolution:
  - SET, hit, full=1 -> NO_RESULTS, table unchanged.
  - SET, hit, full=0 -> store data, full=1 -> RES_WR.
  - SET, miss, free entry exists -> allocate the lowest-index invalid entry, store data, full=1 -> RES_WR.
  - SET, miss, table full -> NO_RESULTS.
  - GET, hit, full=1 -> data_out=stored data, invalidate entry -> RES_RD.
  - GET, hit, full=0, or miss -> NO_RESULTS.
- REPLY: cpu_msg_pulse=1 for exactly one clk_oe cycle; addr_out = latched thread address. Then go to IDLE, busy=0.
- Latency, in clk_oe cycles: beat 2 accepted -> pulse high is 2 (LOOKUP, then REPLY).
- Beat 1 while busy=1 is dropped. The controller retries on its next pass via chan_wait_next_time.
- Channel address 0 is legal. All addresses compare at full width; there is no wrap.

Optional Feature:
- Macro CHAN_OWNER_CHK_EN.
- Defined:
  - each entry stores the writer thread address on SET.
  - GET whose thread address equals the owner of a full entry -> NO_RESULTS; the entry is kept. This prevents a thread reading its own send.
- Undefined: no owner field; any thread may read any full entry.

Test Plan:
- SET ch=0x40 data=0x1234 thr=0x100, then GET ch=0x40 thr=0x200 -> RES_WR with addr_out=0x100, then RES_RD with data_out=0x1234 and addr_out=0x200; entry freed.
- GET ch=0x50 on an empty table -> NO_RESULTS, data_out=0; table unchanged.
- SET ch=0x40 twice, no GET between -> RES_WR, then NO_RESULTS; a following GET returns the first data.
- CHAN_NUM=4: SET on ch 1..5 -> four RES_WR, fifth NO_RESULTS. Then GET ch1, then SET ch5 -> RES_WR into slot 0.
- Beat 1 SET with no THREAD_ADDRESS for TMO_CYC=8 cycles -> busy drops after 8 cycles, no pulse. A strobe during busy is ignored; rst=0 asserted in WAIT_THRD -> immediate idle, outputs 0.
- CHAN_OWNER_CHK_EN: SET and GET ch=0x40 both from thr=0x100 -> NO_RESULTS. GET from thr=0x200 -> RES_RD.
